// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo counter family.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package counter_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // Minimum bits to hold 0..value-1; never returns less than 1 so the
    // result is always usable as a vector width.
    function automatic int clog2(input int value);
        int bits;
        int v;
        bits = 0;
        v    = value - 1;
        while (v > 0) begin
            bits++;
            v = v >> 1;
        end
        if (bits == 0) begin
            bits = 1;
        end
        return bits;
    endfunction

    // Parameter legality: MODULO in 2..2**WIDTH, and PRESCALE >= 2 when
    // the prescaler is actually built.
    function automatic bit params_ok(input int width, input longint modulo,
                                     input int prescale, input bit prescale_en);
        return (modulo >= 2) && (modulo <= (longint'(1) << width)) &&
               (!prescale_en || (prescale >= 2));
    endfunction

endpackage

// File: rtl/mod_counter_prescale.sv
// Divides en into one step pulse every PRESCALE en cycles; step is combinational from the prescale register.
// Latency: prescale state updates one clock after en; step is zero latency from state.
// Backpressure: none; en=0 freezes the prescaler, clr_i returns it to 0.
module mod_counter_prescale
    import counter_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en,
    output logic step
);

    localparam int             PW   = clog2(PRESCALE);
    localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt;

    // Step is offered on the last slot of each prescale interval.
    always_comb begin
        step = (pcnt == LAST);
    end

    // Count en cycles, wrapping to 0 after the step slot.
    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= step ? '0 : pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Modulo-N up/down address counter with load, clear, wrap/saturate and cascadable tc (optional prescaler under MOD_COUNTER_PRESCALE_EN).
// Latency: count/wrap/sat update one clock after the qualifying input; tc is combinational, zero latency.
// Backpressure: none; en is a plain enable, chain instances by driving the next en from tc.
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULO   = 256,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    // Limits are held one bit wider than count so MODULO == 2**WIDTH fits.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULO);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULO - 1);
    localparam logic [WIDTH-1:0] MAX_CNT = MAX_EXT[WIDTH-1:0];

`ifdef MOD_COUNTER_PRESCALE_EN
    localparam bit PRESCALE_ON = 1'b1;
`else
    localparam bit PRESCALE_ON = 1'b0;
`endif

    generate
        if (!params_ok(WIDTH, longint'(MODULO), PRESCALE, PRESCALE_ON)) begin : g_param_check
            $error("mod_counter: illegal WIDTH/MODULO/PRESCALE combination");
        end
    endgenerate

    logic step;

`ifdef MOD_COUNTER_PRESCALE_EN
    mod_counter_prescale #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk   (clk),
        .reset (reset),
        .clr_i (clr | load),
        .en    (en),
        .step  (step)
    );
`else
    assign step = 1'b1;
`endif

    logic             at_top;
    logic             at_bot;
    logic             at_limit;
    logic             adv;
    logic [WIDTH-1:0] load_clamped;

    // Limit detection, terminal count and load clamping.
    always_comb begin
        at_top       = ({1'b0, count} == MAX_EXT);
        at_bot       = (count == '0);
        at_limit     = (up_dn == CNT_DN) ? at_bot : at_top;
        adv          = en & step;
        tc           = adv & at_limit;
        load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_CNT : load_val;
    end

    // Count state: reset > clr > load > enabled step; wrap is a one-cycle pulse, sat is sticky.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
            wrap  <= 1'b0;
            sat   <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            wrap  <= 1'b0;
            sat   <= 1'b0;
        end else if (adv) begin
            if (at_limit) begin
                if (SATURATE != 0) begin
                    sat  <= 1'b1;
                    wrap <= 1'b0;
                end else begin
                    count <= (up_dn == CNT_UP) ? '0 : MAX_CNT;
                    wrap  <= 1'b1;
                end
            end else begin
                count <= (up_dn == CNT_UP) ? count + 1'b1 : count - 1'b1;
                wrap  <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: directed vector table, hand-written corner sequences, and randomized run against an integer model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mod_counter;

`ifdef MOD_COUNTER_PRESCALE_EN
    localparam int PRESC = 4;
`else
    localparam int PRESC = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       cas_en = 1'b0;
    logic       zero1 = 1'b0;
    logic       one1 = 1'b1;
    logic [1:0] zero2 = 2'd0;

    logic [7:0] cnt_a, cnt_s, cnt_b;
    logic [3:0] cnt_f;
    logic [1:0] cnt_c, cnt_r;
    logic tc_a, tc_s, tc_b, tc_f, tc_c, tc_r;
    logic wr_a, wr_s, wr_b, wr_f, wr_c, wr_r;
    logic sat_a, sat_s, sat_b, sat_f, sat_c, sat_r;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(8), .MODULO(10), .SATURATE(0), .PRESCALE(4)) u_a (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .count(cnt_a), .tc(tc_a), .wrap(wr_a), .sat(sat_a));
    mod_counter #(.WIDTH(8), .MODULO(10), .SATURATE(1), .PRESCALE(4)) u_s (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .count(cnt_s), .tc(tc_s), .wrap(wr_s), .sat(sat_s));
    mod_counter #(.WIDTH(8), .MODULO(256), .SATURATE(0), .PRESCALE(4)) u_b (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .count(cnt_b), .tc(tc_b), .wrap(wr_b), .sat(sat_b));
    mod_counter #(.WIDTH(4), .MODULO(16), .SATURATE(1), .PRESCALE(4)) u_f (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val[3:0]),
        .en(en), .up_dn(up_dn), .count(cnt_f), .tc(tc_f), .wrap(wr_f), .sat(sat_f));
    mod_counter #(.WIDTH(2), .MODULO(3), .SATURATE(0), .PRESCALE(4)) u_col (
        .clk(clk), .reset(reset), .clr(zero1), .load(zero1), .load_val(zero2),
        .en(cas_en), .up_dn(one1), .count(cnt_c), .tc(tc_c), .wrap(wr_c), .sat(sat_c));
    mod_counter #(.WIDTH(2), .MODULO(4), .SATURATE(0), .PRESCALE(4)) u_row (
        .clk(clk), .reset(reset), .clr(zero1), .load(zero1), .load_val(zero2),
        .en(tc_c), .up_dn(one1), .count(cnt_r), .tc(tc_r), .wrap(wr_r), .sat(sat_r));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit c, input bit l, input logic [7:0] lv,
                         input bit e, input bit u);
        reset = r; clr = c; load = l; load_val = lv; en = e; up_dn = u;
    endtask

    // Behavioural model: plain integers, prescale slot counted as en cycles.
    typedef struct {
        int c;
        bit w;
        bit s;
        int p;
    } mstate_t;

    function automatic mstate_t mstep(input mstate_t m, input int modulo, input bit satm,
                                      input bit r, input bit c, input bit l, input int lv,
                                      input bit e, input bit u);
        mstate_t n;
        bit stepnow;
        n = m;
        if (r || c || l) begin
            n.p = 0; n.w = 0; n.s = 0;
            n.c = (r || c) ? 0 : ((lv >= modulo) ? modulo - 1 : lv);
        end else if (e) begin
            stepnow = (m.p == PRESC - 1);
            n.p = stepnow ? 0 : m.p + 1;
            n.w = 0;
            if (stepnow) begin
                if (u ? (m.c == modulo - 1) : (m.c == 0)) begin
                    if (satm) n.s = 1;
                    else begin
                        n.c = u ? 0 : modulo - 1;
                        n.w = 1;
                    end
                end else begin
                    n.c = u ? m.c + 1 : m.c - 1;
                end
            end
        end else begin
            n.w = 0;
        end
        return n;
    endfunction

    function automatic bit mtc(input mstate_t m, input int modulo, input bit e, input bit u);
        return e && (m.p == PRESC - 1) && (u ? (m.c == modulo - 1) : (m.c == 0));
    endfunction

    typedef struct {
        bit rst, clr, ld;
        logic [7:0] lv;
        bit en, up;
        bit tc_a;
        int cnt_a;
        bit wr_a;
        int cnt_s;
        bit sat_s;
    } vec_t;

    vec_t tbl[13];

    initial begin
        mstate_t ma, ms, mb, mf;
        bit r, c, l, e, u;
        logic [7:0] lv;

        // Reset state
        drive(1, 0, 0, 8'd0, 0, 1);
        tick();
        tick();
        chk("reset_cnt_a", cnt_a, 0);
        chk("reset_wrap_a", wr_a, 0);
        chk("reset_sat_s", sat_s, 0);
        chk("reset_cnt_f", cnt_f, 0);

        // Reset mid-count on a 256-modulo instance
        drive(0, 0, 1, 8'd37, 0, 1);
        tick();
        chk("midrst_load37", cnt_b, 37);
        drive(0, 0, 0, 8'd0, 1, 1);
        tick();
        chk("midrst_step", cnt_b, (PRESC == 1) ? 38 : 37);
        drive(1, 0, 0, 8'd0, 1, 1);
        tick();
        chk("midrst_cnt0", cnt_b, 0);
        chk("midrst_wrap0", wr_b, 0);
        chk("midrst_sat0", sat_b, 0);
        tick();
        chk("midrst_hold0", cnt_b, 0);
        drive(0, 0, 0, 8'd0, 0, 1);
        tick();

`ifndef MOD_COUNTER_PRESCALE_EN
        // Vector table (MODULO=10): u_a wraps, u_s saturates
        tbl[0]  = '{0, 0, 1, 8'd7,   0, 1, 0, 7, 0, 7, 0};
        tbl[1]  = '{0, 0, 0, 8'd0,   1, 1, 0, 8, 0, 8, 0};
        tbl[2]  = '{0, 0, 0, 8'd0,   1, 1, 0, 9, 0, 9, 0};
        tbl[3]  = '{0, 0, 0, 8'd0,   1, 1, 1, 0, 1, 9, 1};
        tbl[4]  = '{0, 0, 0, 8'd0,   0, 1, 0, 0, 0, 9, 1};
        tbl[5]  = '{0, 0, 0, 8'd0,   1, 0, 1, 9, 1, 8, 1};
        tbl[6]  = '{0, 1, 1, 8'd5,   1, 1, 1, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 8'd0,   1, 0, 1, 9, 1, 0, 1};
        tbl[8]  = '{0, 0, 1, 8'd12,  0, 1, 0, 9, 0, 9, 0};
        tbl[9]  = '{0, 0, 1, 8'd255, 0, 1, 0, 9, 0, 9, 0};
        tbl[10] = '{0, 0, 0, 8'd0,   1, 0, 0, 8, 0, 8, 0};
        tbl[11] = '{0, 0, 1, 8'd0,   1, 1, 0, 0, 0, 0, 0};
        tbl[12] = '{1, 0, 1, 8'd3,   1, 1, 0, 0, 0, 0, 0};
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rst, tbl[i].clr, tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].up);
            #3;
            chk($sformatf("vec%0d_tc_a", i), tc_a, tbl[i].tc_a);
            tick();
            chk($sformatf("vec%0d_cnt_a", i), cnt_a, tbl[i].cnt_a);
            chk($sformatf("vec%0d_wrap_a", i), wr_a, tbl[i].wr_a);
            chk($sformatf("vec%0d_cnt_s", i), cnt_s, tbl[i].cnt_s);
            chk($sformatf("vec%0d_sat_s", i), sat_s, tbl[i].sat_s);
        end

        // Full up sequence 0..9,0 with tc and wrap placement
        drive(0, 1, 0, 8'd0, 0, 1);
        tick();
        drive(0, 0, 0, 8'd0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            #3;
            chk($sformatf("upseq%0d_tc", i), tc_a, (i == 9));
            tick();
            chk($sformatf("upseq%0d_cnt", i), cnt_a, (i + 1) % 10);
            chk($sformatf("upseq%0d_wrap", i), wr_a, (i == 9));
        end
        drive(0, 0, 0, 8'd0, 0, 1);
        tick();
        chk("upseq_wrap_drop", wr_a, 0);

        // Cascade: column MODULO=3 tc drives row MODULO=4 en
        cas_en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            #3;
            chk($sformatf("cas%0d_tc_row", i), tc_r,
                (((i - 1) % 3) == 2) && ((((i - 1) / 3) % 4) == 3));
            tick();
            chk($sformatf("cas%0d_col", i), cnt_c, i % 3);
            chk($sformatf("cas%0d_row", i), cnt_r, (i / 3) % 4);
            chk($sformatf("cas%0d_wrap_col", i), wr_c, (i % 3) == 0);
            chk($sformatf("cas%0d_wrap_row", i), wr_r, (i == 12));
        end
        cas_en = 1'b0;
        chk("cas_sat_col", sat_c, 0);
        chk("cas_sat_row", sat_r, 0);
`else
        // Prescaler: step every 4th en cycle, en gaps stretch the interval
        drive(1, 0, 0, 8'd0, 0, 1);
        tick();
        drive(0, 0, 0, 8'd0, 1, 1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("pre%0d_cnt", i), cnt_a, (i == 4) ? 1 : 0);
        end
        for (int i = 5; i <= 10; i++) begin
            en = (i == 7 || i == 8) ? 1'b0 : 1'b1;
            tick();
            chk($sformatf("pre%0d_cnt", i), cnt_a, (i == 10) ? 2 : 1);
        end
        en = 1'b0;
`endif

        // Randomized run against the integer model
        drive(1, 0, 0, 8'd0, 0, 1);
        tick();
        ma = '{0, 0, 0, 0};
        ms = ma; mb = ma; mf = ma;
        for (int k = 0; k < 400; k++) begin
            r  = ($urandom_range(0, 49) == 0);
            c  = ($urandom_range(0, 15) == 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = ($urandom_range(0, 4) != 0) ? (k / 40) % 2 == 0 : $urandom_range(0, 1) == 1;
            lv = 8'($urandom_range(0, 255));
            drive(r, c, l, lv, e, u);
            #3;
            chk("rnd_tc_a", tc_a, mtc(ma, 10, e, u));
            chk("rnd_tc_s", tc_s, mtc(ms, 10, e, u));
            chk("rnd_tc_b", tc_b, mtc(mb, 256, e, u));
            chk("rnd_tc_f", tc_f, mtc(mf, 16, e, u));
            ma = mstep(ma, 10, 0, r, c, l, int'(lv), e, u);
            ms = mstep(ms, 10, 1, r, c, l, int'(lv), e, u);
            mb = mstep(mb, 256, 0, r, c, l, int'(lv), e, u);
            mf = mstep(mf, 16, 1, r, c, l, int'(lv) % 16, e, u);
            tick();
            chk("rnd_cnt_a", cnt_a, ma.c);
            chk("rnd_wrap_a", wr_a, ma.w);
            chk("rnd_sat_a", sat_a, ma.s);
            chk("rnd_cnt_s", cnt_s, ms.c);
            chk("rnd_wrap_s", wr_s, ms.w);
            chk("rnd_sat_s", sat_s, ms.s);
            chk("rnd_cnt_b", cnt_b, mb.c);
            chk("rnd_wrap_b", wr_b, mb.w);
            chk("rnd_sat_b", sat_b, mb.s);
            chk("rnd_cnt_f", cnt_f, mf.c);
            chk("rnd_wrap_f", wr_f, mf.w);
            chk("rnd_sat_f", sat_f, mf.s);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
Fully synchronous, parametrised modulo-N up/down counter for the convolution datapath. It generates row, column, kernel-tap and pixel addresses.
- Replaces ripple-style counters: every bit changes on clk, with no derived clocks.
- Adds load, clear, direction, wrap/saturate mode and a terminal-count output so instances can cascade (column counter tc drives row counter en).

Parameters:
WIDTH, 8, count width in bits
MODULO, 256, count range 0..MODULO-1; legal range 2..2**WIDTH
SATURATE, 0, 0 = wrap at the limits, 1 = hold at the limits
PRESCALE, 4, en cycles per count step; used only with MOD_COUNTER_PRESCALE_EN; legal minimum 2

Ports:
clk  input  1  clock, all state changes on the rising edge
reset  input  1  synchronous, active-high reset
clr  input  1  synchronous clear of count to 0
load  input  1  load count from load_val
load_val  input  WIDTH  value to load
en  input  1  count enable
up_dn  input  1  1 = count up, 0 = count down
count  output  WIDTH  registered count value
tc  output  1  combinational terminal count
wrap  output  1  registered one-cycle wrap pulse
sat  output  1  registered sticky saturation flag

Behaviour:
- Reset values: reset (synchronous, active-high) forces count=0, wrap=0 and sat=0 on the next rising edge of clk.
- Priority per cycle: reset > clr > load > en. Lower-priority requests in the same cycle are ignored.
- clr: count=0, sat=0, wrap=0.
- load: count=load_val, sat=0, wrap=0. If load_val >= MODULO, count=MODULO-1 (clamped).
- en=1, up_dn=1:
  - count<MODULO-1: count+1.
  - count==MODULO-1, SATURATE=0: count=0 and wrap=1 for exactly one cycle.
  - count==MODULO-1, SATURATE=1: count holds and sat=1.
- en=1, up_dn=0:
  - count>0: count-1.
  - count==0, SATURATE=0: count=MODULO-1 and wrap=1.
  - count==0, SATURATE=1: count holds and sat=1.
- en=0: count holds; wrap=0; sat holds.
- tc = en & step & ((up_dn & count==MODULO-1) | (~up_dn & count==0)).
  - step=1 when prescaling is compiled out.
  - tc is combinational with zero latency, so a downstream counter's en advances in the same edge as the wrap.
- tc is asserted regardless of SATURATE.
- Latency: count and wrap update one clock after the qualifying input.
- Direction change mid-run takes effect on the same edge; no glitch or skipped value.
- Arithmetic: a WIDTH+1-bit internal compare prevents overflow when MODULO==2**WIDTH.
- Reset or clr asserted mid-count overrides en in that cycle; counting resumes from 0 on the next en.

Optional Feature:
Macro MOD_COUNTER_PRESCALE_EN.
- Defined:
  - An internal prescaler of width clog2(PRESCALE) counts en cycles.
  - step=1 only on en cycles where the prescaler == PRESCALE-1; the prescaler then returns to 0.
  - count advances, and wrap/sat/tc apply, only when en & step.
  - reset, clr and load zero the prescaler.
  - en=0 freezes the prescaler.
- Not defined: no prescaler logic is present; step=1; count advances on every en cycle; the PRESCALE parameter is ignored.

Decomposition:
- Package counter_pkg:
  - CNT_UP=1'b1, CNT_DN=1'b0
  - clog2 constant function
  - parameter-legality check helper (MODULO<=2**WIDTH, PRESCALE>=2)
- Sub-module mod_counter_prescale: instantiated only under MOD_COUNTER_PRESCALE_EN.
  - Ports: clk, reset, clr_i (=clr|load), en, step.
  - Keeps the main counter free of conditional logic beyond the step gate.

Test Plan:
- Reset mid-count: count at 37, assert reset -> count=0, wrap=0, sat=0 on the next edge; count holds at 0 while reset is high even with en=1.
- MODULO=10, SATURATE=0, up, en=1 from 0 -> sequence 0..9,0; tc=1 exactly while count==9; wrap=1 exactly in the cycle count shows 0.
- MODULO=10, down from 0 -> count=9 and wrap=1; then with SATURATE=1, down from 0 -> count holds 0, sat=1 sticky until clr.
- Priority: clr=1, load=1 (load_val=5) and en=1 together -> count=0; load alone with load_val=12 at MODULO=10 -> count=9.
- Cascade: column mod_counter (MODULO=3) tc drives row mod_counter (MODULO=4) en -> row increments on every third column step; after 12 steps both read 0 and both wrap pulses coincide.
- With MOD_COUNTER_PRESCALE_EN, PRESCALE=4, en held high -> count increments every 4th cycle; en dropped for 2 cycles mid-interval extends that interval by exactly 2 cycles.
